// File: rtl/mem_access_pkg.sv
// Shared definitions for the memory-access stage.
//   ma_state_e : FSM state encodings (IDLE/REQ/XFER/DONE)
//   MA_*       : funct3 width codes for loads/stores
//   ma_len     : transfer length in bytes for a width code
package mem_access_pkg;

  typedef enum logic [1:0] {
    MA_IDLE = 2'd0,
    MA_REQ  = 2'd1,
    MA_XFER = 2'd2,
    MA_DONE = 2'd3
  } ma_state_e;

  localparam logic [2:0] MA_B  = 3'b000;
  localparam logic [2:0] MA_H  = 3'b001;
  localparam logic [2:0] MA_W  = 3'b010;
  localparam logic [2:0] MA_BU = 3'b100;
  localparam logic [2:0] MA_HU = 3'b101;

  // width[2] (unsigned) does not change the length; 10 and 11 are both a word.
  function automatic logic [2:0] ma_len(input logic [2:0] width);
    case (width[1:0])
      2'b00:   return 3'd1;
      2'b01:   return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/mem_access_extend.sv
// ma_extend: sign/zero extension of assembled load bytes.
//   data_i  : little-endian bytes as assembled by the transfer (upper bytes ignored
//             for sub-word widths)
//   width_i : funct3 width code
//   data_o  : extended 32-bit load result
module ma_extend
  import mem_access_pkg::*;
(
  input  logic [31:0] data_i,
  input  logic [2:0]  width_i,
  output logic [31:0] data_o
);

  always_comb begin
    data_o = data_i;
    case (width_i)
      MA_B:    data_o = {{24{data_i[7]}}, data_i[7:0]};
      MA_BU:   data_o = {24'd0, data_i[7:0]};
      MA_H:    data_o = {{16{data_i[15]}}, data_i[15:0]};
      MA_HU:   data_o = {16'd0, data_i[15:0]};
      MA_W:    data_o = data_i;
      default: data_o = data_i;
    endcase
  end

endmodule

// File: rtl/mem_access.sv
// mem_access: memory-access stage. Performs loads/stores byte-serially over an
// 8-bit RAM port, extends load data, and forwards register write-back.
//   clk, rst (sync, active-high), rdy (global freeze)
//   we_in/waddr_in/wdata_in : write-back from EX
//   ma_re/ma_we/ma_width/ma_addr/ma_wdata : memory request from EX
//   mem_gnt, mem_din        : arbiter grant, RAM read data (one cycle latency)
//   we/waddr/wdata          : write-back to MEM/WB
//   stall_req               : freeze upstream stages
//   mem_req/mem_a/mem_dout/mem_wr : RAM port
module mem_access
  import mem_access_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rdy,
  input  logic              we_in,
  input  logic [4:0]        waddr_in,
  input  logic [31:0]       wdata_in,
  input  logic              ma_re,
  input  logic              ma_we,
  input  logic [2:0]        ma_width,
  input  logic [31:0]       ma_addr,
  input  logic [31:0]       ma_wdata,
  input  logic              mem_gnt,
  input  logic [7:0]        mem_din,
  output logic              we,
  output logic [4:0]        waddr,
  output logic [31:0]       wdata,
  output logic              stall_req,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_a,
  output logic [7:0]        mem_dout,
  output logic              mem_wr
);

  ma_state_e   state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic        st_q, st_d;
  logic [2:0]  width_q, width_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] sdata_q, sdata_d;
  logic        we_q, we_d;
  logic [4:0]  waddr_q, waddr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] ld_q, ld_d;

  logic [2:0]  len;
  logic [2:0]  a_idx;
  logic [31:0] a_off;
  logic [31:0] ld_ext;

  assign len = ma_len(width_q);

  // While frozen mid-load, re-drive the address whose byte is still pending
  // capture, so mem_din carries that byte again on the resume cycle.
  always_comb begin
    a_idx = cnt_q;
    if (!st_q && !rdy && cnt_q != 3'd0) a_idx = cnt_q - 3'd1;
  end

  assign a_off = addr_q + {29'd0, a_idx};

  ma_extend u_ext (
    .data_i  (ld_q),
    .width_i (width_q),
    .data_o  (ld_ext)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    st_d      = st_q;
    width_d   = width_q;
    addr_d    = addr_q;
    sdata_d   = sdata_q;
    we_d      = we_q;
    waddr_d   = waddr_q;
    wdata_d   = wdata_q;
    ld_d      = ld_q;
    we        = 1'b0;
    waddr     = 5'd0;
    wdata     = 32'd0;
    stall_req = 1'b0;
    mem_req   = 1'b0;
    mem_a     = '0;
    mem_dout  = 8'd0;
    mem_wr    = 1'b0;

    case (state_q)
      MA_IDLE: begin
        waddr = waddr_in;
        wdata = wdata_in;
        if (ma_re || ma_we) begin
          stall_req = 1'b1;
          state_d   = MA_REQ;
          st_d      = ma_we;          // store wins if both are set
          width_d   = ma_width;
          addr_d    = ma_addr;
          sdata_d   = ma_wdata;
          we_d      = we_in;
          waddr_d   = waddr_in;
          wdata_d   = wdata_in;
          ld_d      = 32'd0;
          cnt_d     = 3'd0;
        end else begin
          we = we_in;
        end
      end
      MA_REQ: begin
        stall_req = 1'b1;
        mem_req   = 1'b1;
        if (mem_gnt) begin
          state_d = MA_XFER;
          cnt_d   = 3'd0;
        end
      end
      MA_XFER: begin
        stall_req = 1'b1;
        mem_req   = 1'b1;
        mem_a     = a_off[ADDR_W-1:0];
        if (st_q) begin
          mem_wr = 1'b1;
          case (cnt_q[1:0])
            2'd0:    mem_dout = sdata_q[7:0];
            2'd1:    mem_dout = sdata_q[15:8];
            2'd2:    mem_dout = sdata_q[23:16];
            default: mem_dout = sdata_q[31:24];
          endcase
          if (cnt_q == len - 3'd1) state_d = MA_DONE;
          else                     cnt_d   = cnt_q + 3'd1;
        end else begin
          // Read data lags the address by one cycle: cnt k captures byte k-1,
          // so a load needs one extra capture-only cycle at cnt == n.
          case (cnt_q)
            3'd1:    ld_d[7:0]   = mem_din;
            3'd2:    ld_d[15:8]  = mem_din;
            3'd3:    ld_d[23:16] = mem_din;
            3'd4:    ld_d[31:24] = mem_din;
            default: ;
          endcase
          if (cnt_q == len) begin
            state_d = MA_DONE;
            cnt_d   = 3'd0;
          end else begin
            cnt_d = cnt_q + 3'd1;
          end
        end
      end
      MA_DONE: begin
        we      = we_q;
        waddr   = waddr_q;
        wdata   = st_q ? wdata_q : ld_ext;
        state_d = MA_IDLE;
        cnt_d   = 3'd0;
      end
      default: state_d = MA_IDLE;
    endcase

    if (!rdy) begin
      mem_wr  = 1'b0;
      mem_req = 1'b0;
    end

    // Reset takes effect on the outputs in the same cycle it is asserted.
    if (rst) begin
      stall_req = 1'b0;
      mem_req   = 1'b0;
      mem_wr    = 1'b0;
      mem_a     = '0;
      mem_dout  = 8'd0;
      we        = we_in;
      waddr     = waddr_in;
      wdata     = wdata_in;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= MA_IDLE;
      cnt_q   <= 3'd0;
      st_q    <= 1'b0;
      width_q <= 3'd0;
      addr_q  <= 32'd0;
      sdata_q <= 32'd0;
      we_q    <= 1'b0;
      waddr_q <= 5'd0;
      wdata_q <= 32'd0;
      ld_q    <= 32'd0;
    end else if (rdy) begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      st_q    <= st_d;
      width_q <= width_d;
      addr_q  <= addr_d;
      sdata_q <= sdata_d;
      we_q    <= we_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
      ld_q    <= ld_d;
    end
  end

endmodule

// File: tb/tb_mem_access.sv
module tb_mem_access;

  logic        clk = 1'b0;
  logic        rst, rdy, we_in;
  logic [4:0]  waddr_in;
  logic [31:0] wdata_in;
  logic        ma_re, ma_we;
  logic [2:0]  ma_width;
  logic [31:0] ma_addr, ma_wdata;
  logic        mem_gnt;
  logic [7:0]  mem_din;
  logic        we;
  logic [4:0]  waddr;
  logic [31:0] wdata;
  logic        stall_req, mem_req;
  logic [31:0] mem_a;
  logic [7:0]  mem_dout;
  logic        mem_wr;

  mem_access #(.ADDR_W(32)) dut (
    .clk(clk), .rst(rst), .rdy(rdy),
    .we_in(we_in), .waddr_in(waddr_in), .wdata_in(wdata_in),
    .ma_re(ma_re), .ma_we(ma_we), .ma_width(ma_width),
    .ma_addr(ma_addr), .ma_wdata(ma_wdata),
    .mem_gnt(mem_gnt), .mem_din(mem_din),
    .we(we), .waddr(waddr), .wdata(wdata),
    .stall_req(stall_req), .mem_req(mem_req),
    .mem_a(mem_a), .mem_dout(mem_dout), .mem_wr(mem_wr)
  );

  always #5 clk = ~clk;

  // 4 KiB RAM device, aliased on the low 12 address bits; read data one cycle late.
  logic [7:0]  ram [0:4095];
  logic        pl_en;
  logic [11:0] pl_a;
  logic [7:0]  pl_d;
  always @(posedge clk) begin
    mem_din <= ram[mem_a[11:0]];
    if (pl_en)       ram[pl_a] <= pl_d;
    else if (mem_wr) ram[mem_a[11:0]] <= mem_dout;
  end

  // Reference memory contents as the spec says they should be.
  logic [7:0]  ref_mem [0:4095];
  logic [39:0] trace [$];

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  function automatic int nbytes(input logic [2:0] w);
    return (w[1:0] == 2'b00) ? 1 : (w[1:0] == 2'b01) ? 2 : 4;
  endfunction

  function automatic logic [31:0] model_load(input logic [2:0] w, input logic [31:0] a);
    int n = nbytes(w);
    logic [31:0] v = 32'd0;
    for (int i = 0; i < n; i++) v = v | (32'(ref_mem[12'(a + 32'(i))]) << (8 * i));
    if (!w[2] && n < 4 && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8 * n));
    return v;
  endfunction

  task automatic poke(input logic [31:0] a, input logic [7:0] d);
    ref_mem[a[11:0]] = d;
    pl_a = a[11:0]; pl_d = d; pl_en = 1'b1;
    @(posedge clk); #1;
    pl_en = 1'b0;
  endtask

  // Store trace must be exactly bytes 0..n-1 of sd at a, a+1, ... (wrapping).
  task automatic check_store(input logic [31:0] a, input logic [31:0] sd, input logic [2:0] w);
    int n = nbytes(w);
    chk("st_nbytes", trace.size(), n);
    for (int i = 0; i < n && i < trace.size(); i++)
      chk("st_byte", trace[i], {a + 32'(i), sd[8*i +: 8]});
    for (int i = 0; i < n; i++) ref_mem[12'(a + 32'(i))] = sd[8*i +: 8];
  endtask

  task automatic run_op(input logic re, input logic st, input logic [2:0] w,
                        input logic [31:0] a, input logic [31:0] sd,
                        input logic wi, input logic [4:0] wa, input logic [31:0] alu,
                        input int gdly, input int rdy_at, input int rdy_len,
                        output logic o_we, output logic [4:0] o_wa,
                        output logic [31:0] o_wd, output int lat);
    int bad = 0;
    trace.delete();
    lat = 0; o_we = 1'b0; o_wa = 5'd0; o_wd = 32'd0;
    @(posedge clk); #1;
    ma_re = re; ma_we = st; ma_width = w; ma_addr = a; ma_wdata = sd;
    we_in = wi; waddr_in = wa; wdata_in = alu;
    mem_gnt = (gdly == 0); rdy = 1'b1;
    #2;
    chk("req_stall", stall_req, 1);
    chk("req_we", we, 0);
    for (int c = 2; c <= 60; c++) begin
      @(posedge clk); #1;
      if (c == 2) begin
        ma_re = 1'b0; ma_we = 1'b0; we_in = 1'b0; waddr_in = 5'd0; wdata_in = 32'd0;
      end
      mem_gnt = (c >= 2 + gdly);
      rdy = !(c >= rdy_at && c < rdy_at + rdy_len);
      #2;
      if (!mem_gnt && mem_wr) bad++;
      if (mem_wr) trace.push_back({mem_a, mem_dout});
      if (!stall_req) begin
        lat = c; o_we = we; o_wa = waddr; o_wd = wdata;
        break;
      end
    end
    rdy = 1'b1; mem_gnt = 1'b1;
    if (lat == 0) begin
      n_vec++; n_err++;
      $display("FAIL op_timeout: got no DONE within 60 cycles, expected one");
    end
    if (gdly > 0) chk("wr_before_gnt", bad, 0);
  endtask

  typedef struct {
    logic        re, st;
    logic [2:0]  w;
    logic [31:0] a, sd, alu;
    int          gd;
    logic        ewe;
    logic [31:0] ewd;
    int          lat;
  } vec_t;

  vec_t tv [10];

  initial begin
    logic        o_we;
    logic [4:0]  o_wa;
    logic [31:0] o_wd;
    int          lat;

    rst = 1'b1; rdy = 1'b1; we_in = 1'b0; waddr_in = 5'd0; wdata_in = 32'd0;
    ma_re = 1'b0; ma_we = 1'b0; ma_width = 3'd0; ma_addr = 32'd0; ma_wdata = 32'd0;
    mem_gnt = 1'b1; pl_en = 1'b0; pl_a = 12'd0; pl_d = 8'd0;

    // Preload the whole RAM with random bytes while held in reset.
    @(posedge clk); #1;
    for (int i = 0; i < 4096; i++) begin
      logic [7:0] d;
      d = 8'($urandom);
      ref_mem[i] = d;
      pl_a = 12'(i); pl_d = d; pl_en = 1'b1;
      @(posedge clk); #1;
    end
    pl_en = 1'b0;

    // Reset state: outputs quiet, write-back passes through.
    we_in = 1'b1; waddr_in = 5'd7; wdata_in = 32'h0000_1234;
    #2;
    chk("rst_stall", stall_req, 0);
    chk("rst_mem_req", mem_req, 0);
    chk("rst_mem_wr", mem_wr, 0);
    chk("rst_mem_a", mem_a, 0);
    chk("rst_mem_dout", mem_dout, 0);
    chk("rst_we", we, 1);
    @(posedge clk); #1;
    rst = 1'b0;
    #2;
    chk("post_rst_we", we, 1);
    chk("post_rst_waddr", waddr, 7);
    chk("post_rst_wdata", wdata, 32'h0000_1234);
    chk("post_rst_stall", stall_req, 0);

    poke(32'h100, 8'h11); poke(32'h101, 8'h22); poke(32'h102, 8'h33); poke(32'h103, 8'h44);
    poke(32'h040, 8'h80);
    poke(32'hFFF, 8'hEF); poke(32'h000, 8'hBE);
    poke(32'h304, 8'h00);

    //          re    st    w       a             sd            alu           gd ewe   ewd           lat
    tv[0] = '{1'b1, 1'b0, 3'b010, 32'h100,      32'h0,        32'h0,        0, 1'b1, 32'h44332211, 8};
    tv[1] = '{1'b1, 1'b0, 3'b000, 32'h040,      32'h0,        32'h0,        0, 1'b1, 32'hFFFFFF80, 5};
    tv[2] = '{1'b1, 1'b0, 3'b100, 32'h040,      32'h0,        32'h0,        0, 1'b1, 32'h00000080, 5};
    tv[3] = '{1'b1, 1'b0, 3'b101, 32'hFFFFFFFF, 32'h0,        32'h0,        0, 1'b1, 32'h0000BEEF, 6};
    tv[4] = '{1'b1, 1'b0, 3'b001, 32'hFFFFFFFF, 32'h0,        32'h0,        0, 1'b1, 32'hFFFFBEEF, 6};
    tv[5] = '{1'b0, 1'b1, 3'b010, 32'h300,      32'hCAFEF00D, 32'h5A5A0005, 3, 1'b0, 32'h5A5A0005, 10};
    tv[6] = '{1'b1, 1'b0, 3'b010, 32'h300,      32'h0,        32'h0,        0, 1'b1, 32'hCAFEF00D, 8};
    tv[7] = '{1'b1, 1'b1, 3'b000, 32'h305,      32'h000000A5, 32'h00000077, 0, 1'b0, 32'h00000077, 4};
    tv[8] = '{1'b1, 1'b0, 3'b100, 32'h305,      32'h0,        32'h0,        0, 1'b1, 32'h000000A5, 5};
    tv[9] = '{1'b1, 1'b0, 3'b011, 32'h302,      32'h0,        32'h0,        0, 1'b1, 32'hA500CAFE, 8};

    for (int i = 0; i < 10; i++) begin
      run_op(tv[i].re, tv[i].st, tv[i].w, tv[i].a, tv[i].sd, !tv[i].st, 5'(i + 1), tv[i].alu,
             tv[i].gd, 0, 0, o_we, o_wa, o_wd, lat);
      chk("tv_we", o_we, tv[i].ewe);
      chk("tv_waddr", o_wa, 5'(i + 1));
      chk("tv_wdata", o_wd, tv[i].ewd);
      chk("tv_lat", lat, tv[i].lat);
      if (tv[i].st) check_store(tv[i].a, tv[i].sd, tv[i].w);
      else          chk("tv_ld_nowr", trace.size(), 0);
    end

    // SH across a byte boundary: two writes, no write-back.
    run_op(1'b0, 1'b1, 3'b001, 32'h203, 32'h1234BEEF, 1'b0, 5'd3, 32'h0, 0, 0, 0, o_we, o_wa, o_wd, lat);
    chk("sh_we", o_we, 0);
    chk("sh_lat", lat, 5);
    chk("sh_nwr", trace.size(), 2);
    if (trace.size() == 2) begin
      chk("sh_wr0", trace[0], {32'h203, 8'hEF});
      chk("sh_wr1", trace[1], {32'h204, 8'hBE});
    end
    for (int i = 0; i < 2; i++) ref_mem[12'h203 + 12'(i)] = (i == 0) ? 8'hEF : 8'hBE;

    // rdy low for two cycles after the first byte of an LW.
    run_op(1'b1, 1'b0, 3'b010, 32'h100, 32'h0, 1'b1, 5'd4, 32'h0, 0, 5, 2, o_we, o_wa, o_wd, lat);
    chk("rdy_lw_wdata", o_wd, 32'h44332211);
    chk("rdy_lw_we", o_we, 1);
    chk("rdy_lw_lat", lat, 10);

    // Reset during the second byte of an SW.
    trace.delete();
    @(posedge clk); #1;
    ma_we = 1'b1; ma_re = 1'b0; ma_width = 3'b010; ma_addr = 32'h400; ma_wdata = 32'h11223344;
    we_in = 1'b0; mem_gnt = 1'b1; rdy = 1'b1;
    @(posedge clk); #1;
    ma_we = 1'b0;
    @(posedge clk); #1; #2;
    chk("rst_sw_b0_wr", mem_wr, 1);
    if (mem_wr) trace.push_back({mem_a, mem_dout});
    @(posedge clk); #1;
    rst = 1'b1;
    #2;
    chk("rst_sw_during_wr", mem_wr, 0);
    @(posedge clk); #1;
    rst = 1'b0; we_in = 1'b1; waddr_in = 5'd9; wdata_in = 32'd5;
    #2;
    chk("rst_sw_after_wr", mem_wr, 0);
    chk("rst_sw_stall", stall_req, 0);
    chk("rst_sw_mem_req", mem_req, 0);
    chk("rst_sw_add_we", we, 1);
    chk("rst_sw_add_waddr", waddr, 9);
    chk("rst_sw_add_wdata", wdata, 5);
    chk("rst_sw_nwr", trace.size(), 1);
    if (trace.size() == 1) chk("rst_sw_wr0", trace[0], {32'h400, 8'h44});
    ref_mem[12'h400] = 8'h44;
    we_in = 1'b0;

    // Randomized operations against the reference model.
    for (int k = 0; k < 60; k++) begin
      logic        st, re, wi;
      logic [2:0]  w;
      logic [31:0] a, sd, alu;
      logic [4:0]  wa;
      int          n, gd, ra, rl, exp_lat;
      st  = 1'($urandom);
      re  = st ? 1'($urandom) : 1'b1;
      w   = 3'($urandom_range(0, 7));
      case ($urandom_range(0, 2))
        0:       a = 32'hFFFF_FFF0 + $urandom_range(0, 15);
        1:       a = 32'h0000_0F00 + $urandom_range(0, 255);
        default: a = $urandom;
      endcase
      sd  = $urandom;
      alu = $urandom;
      wa  = 5'($urandom);
      wi  = st ? 1'($urandom) : 1'b1;
      n   = nbytes(w);
      gd  = $urandom_range(0, 2);
      // rdy stalls only inside the transfer window, where each low cycle
      // costs exactly one cycle.
      rl  = (gd == 0) ? $urandom_range(0, 2) : 0;
      ra  = 3 + $urandom_range(0, n - 1);
      exp_lat = 3 + n + (st ? 0 : 1) + gd + rl;
      run_op(re, st, w, a, sd, wi, wa, alu, gd, ra, rl, o_we, o_wa, o_wd, lat);
      chk("rnd_we", o_we, wi);
      chk("rnd_waddr", o_wa, wa);
      chk("rnd_lat", lat, exp_lat);
      if (st) begin
        chk("rnd_st_wdata", o_wd, alu);
        check_store(a, sd, w);
      end else begin
        chk("rnd_ld_wdata", o_wd, model_load(w, a));
        chk("rnd_ld_nowr", trace.size(), 0);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
